// File: rtl/game_flow_pkg.sv
// Shared state encoding and counter widths for the level-flow controller.
package game_flow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CLEAR = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int TIMER_W = 8;
    localparam int HOLD_W  = 10;

endpackage

// File: rtl/frame_sec_timer.sv
// Tick prescaler feeding a saturating down-counter; one instance each for
// the level seconds, the end-of-level hold and the overlay blink.
module frame_sec_timer
    import game_flow_pkg::*;
#(
    parameter int                 PRESCALE    = 60,
    parameter int                 CNT_W       = TIMER_W,
    parameter logic [CNT_W-1:0]   RESET_VALUE = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_load,
    input  logic               i_enable,
    input  logic [CNT_W-1:0]   i_load_value,
    output logic [CNT_W-1:0]   o_count
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_count;

    // Load wins over counting; with neither load nor enable the value is frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre   <= '0;
            r_count <= RESET_VALUE;
        end else if (i_load) begin
            r_pre   <= '0;
            r_count <= i_load_value;
        end else if (i_enable && i_tick) begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                if (r_count != '0) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/game_flow_controller.sv
// Level sequencer: start/restart, player gating, countdown, and the
// clear/over hold with a blinking overlay before returning to idle.
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int GEM_COUNT    = 2,
    parameter int FRAME_RATE   = 60,
    parameter int TIME_LIMIT_S = 120,
    parameter int HOLD_FRAMES  = 180,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_tick,
    input  logic               i_start_btn,
    input  logic [3:0]         i_score,
    input  logic               i_p1_hazard,
    input  logic               i_p2_hazard,
    input  logic               i_p1_at_door,
    input  logic               i_p2_at_door,
    output logic [1:0]         o_state,
    output logic               o_gem_reset,
    output logic               o_players_enable,
    output logic [TIMER_W-1:0] o_timer_sec,
    output logic               o_blink,
    output logic               o_level_clear,
    output logic               o_game_over
);

    localparam logic [TIMER_W-1:0] TIME_LOAD  = TIMER_W'(TIME_LIMIT_S);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES - 1);
    // Blink counter starts odd so the first half-period shows blink low.
    localparam logic [HOLD_W-1:0]  BLINK_LOAD = '1;

    game_state_t        r_state;
    game_state_t        w_state_next;
    logic               r_start_prev;
    logic               r_gem_reset;
    logic               w_start_edge;
    logic               w_in_hold;
    logic               w_hazard;
    logic               w_clear_ok;
    logic               w_hold_done;
    logic               w_timer_load;
    logic               w_hold_load;
    logic [TIMER_W-1:0] w_timer_sec;
    logic [HOLD_W-1:0]  w_hold_count;
    logic [HOLD_W-1:0]  w_blink_count;

    assign w_start_edge = i_start_btn & ~r_start_prev;
    assign w_in_hold    = (r_state == CLEAR) || (r_state == OVER);
    assign w_hazard     = i_p1_hazard | i_p2_hazard;
    assign w_clear_ok   = (int'(i_score) >= GEM_COUNT) & i_p1_at_door & i_p2_at_door;
    assign w_hold_done  = w_in_hold & i_frame_tick & (w_hold_count == '0);
    assign w_timer_load = (r_state == IDLE) || (w_state_next == IDLE);
    assign w_hold_load  = ~w_in_hold;

    // History starts high so a button held through reset is not an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b1;
            r_gem_reset  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_start_prev <= i_start_btn;
            r_gem_reset  <= (r_state == IDLE) && w_start_edge;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_state_next = PLAY;
                end
            end
            PLAY: begin
                if (w_hazard) begin
                    w_state_next = OVER;
                end else if (w_timer_sec == '0) begin
                    w_state_next = OVER;
                end else if (w_clear_ok) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR, OVER: begin
                if (w_hold_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    frame_sec_timer #(
        .PRESCALE    (FRAME_RATE),
        .CNT_W       (TIMER_W),
        .RESET_VALUE (TIME_LOAD)
    ) u_level_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_frame_tick),
        .i_load       (w_timer_load),
        .i_enable     (r_state == PLAY),
        .i_load_value (TIME_LOAD),
        .o_count      (w_timer_sec)
    );

    // Counts remaining hold frames; zero on a tick means the hold is over.
    frame_sec_timer #(
        .PRESCALE    (1),
        .CNT_W       (HOLD_W),
        .RESET_VALUE ('0)
    ) u_hold_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_frame_tick),
        .i_load       (w_hold_load),
        .i_enable     (w_in_hold),
        .i_load_value (HOLD_LOAD),
        .o_count      (w_hold_count)
    );

    frame_sec_timer #(
        .PRESCALE    (BLINK_FRAMES),
        .CNT_W       (HOLD_W),
        .RESET_VALUE ('0)
    ) u_blink_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_frame_tick),
        .i_load       (w_hold_load),
        .i_enable     (w_in_hold),
        .i_load_value (BLINK_LOAD),
        .o_count      (w_blink_count)
    );

    assign o_state          = r_state;
    assign o_gem_reset      = r_gem_reset;
    assign o_players_enable = (r_state == PLAY);
    assign o_timer_sec      = w_timer_sec;
    assign o_blink          = w_in_hold & ((w_blink_count & HOLD_W'(1)) == '0);
    assign o_level_clear    = (r_state == CLEAR);
    assign o_game_over      = (r_state == OVER);

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench: directed level scenarios plus random play, checked
// against a frame-counting behavioural model of the level rules.
module tb_game_flow_controller;
    import game_flow_pkg::*;

    localparam int GemCount    = 2;
    localparam int FrameRate   = 4;
    localparam int TimeLimit   = 3;
    localparam int HoldFrames  = 5;
    localparam int BlinkFrames = 2;

    logic       clock = 1'b0;
    logic       resetN;
    logic       frameTick, startBtn, p1Hazard, p2Hazard, p1AtDoor, p2AtDoor;
    logic [3:0] score;
    logic [1:0] dutState;
    logic       dutGemReset, dutPlayersEnable, dutBlink, dutLevelClear, dutGameOver;
    logic [7:0] dutTimerSec;

    typedef struct {
        int state;
        int gemReset;
        int playersEnable;
        int timerSec;
        int blink;
        int levelClear;
        int gameOver;
    } outSnapshot_t;

    outSnapshot_t expQ[$];
    int checkCount = 0;
    int errorCount = 0;

    game_state_t modelState;
    int          modelSecs, modelFrames, modelHold;
    bit          modelStartPrev, modelGemReset;

    always #5 clock = ~clock;

    game_flow_controller #(
        .GEM_COUNT    (GemCount),
        .FRAME_RATE   (FrameRate),
        .TIME_LIMIT_S (TimeLimit),
        .HOLD_FRAMES  (HoldFrames),
        .BLINK_FRAMES (BlinkFrames)
    ) dut (
        .i_clk            (clock),
        .i_rst_n          (resetN),
        .i_frame_tick     (frameTick),
        .i_start_btn      (startBtn),
        .i_score          (score),
        .i_p1_hazard      (p1Hazard),
        .i_p2_hazard      (p2Hazard),
        .i_p1_at_door     (p1AtDoor),
        .i_p2_at_door     (p2AtDoor),
        .o_state          (dutState),
        .o_gem_reset      (dutGemReset),
        .o_players_enable (dutPlayersEnable),
        .o_timer_sec      (dutTimerSec),
        .o_blink          (dutBlink),
        .o_level_clear    (dutLevelClear),
        .o_game_over      (dutGameOver)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelState     = IDLE;
        modelSecs      = TimeLimit;
        modelFrames    = 0;
        modelHold      = 0;
        modelStartPrev = 1'b1;
        modelGemReset  = 1'b0;
    endtask

    // One clock of the level rules, using the inputs sampled at this edge.
    task automatic modelStep();
        bit           startEdge;
        game_state_t  target;
        outSnapshot_t snap;
        startEdge      = startBtn && !modelStartPrev;
        modelStartPrev = startBtn;
        modelGemReset  = 1'b0;
        case (modelState)
            IDLE: begin
                if (startEdge) begin
                    modelState    = PLAY;
                    modelGemReset = 1'b1;
                    modelSecs     = TimeLimit;
                    modelFrames   = 0;
                end
            end
            PLAY: begin
                target = PLAY;
                if (p1Hazard || p2Hazard) target = OVER;
                else if (modelSecs == 0) target = OVER;
                else if (score >= GemCount && p1AtDoor && p2AtDoor) target = CLEAR;
                if (frameTick) begin
                    modelFrames++;
                    if (modelFrames == FrameRate) begin
                        modelFrames = 0;
                        if (modelSecs > 0) modelSecs--;
                    end
                end
                if (target != PLAY) modelHold = 0;
                modelState = target;
            end
            default: begin
                if (frameTick) begin
                    if (modelHold == HoldFrames - 1) begin
                        modelState = IDLE;
                        modelSecs  = TimeLimit;
                        modelHold  = 0;
                    end else begin
                        modelHold++;
                    end
                end
            end
        endcase
        snap.state         = int'(modelState);
        snap.gemReset      = int'(modelGemReset);
        snap.playersEnable = (modelState == PLAY) ? 1 : 0;
        snap.timerSec      = modelSecs;
        snap.blink         = (modelState == CLEAR || modelState == OVER) ? (modelHold / BlinkFrames) % 2 : 0;
        snap.levelClear    = (modelState == CLEAR) ? 1 : 0;
        snap.gameOver      = (modelState == OVER) ? 1 : 0;
        expQ.push_back(snap);
    endtask

    task automatic applyStimulus(input logic tick, input logic start, input int sc,
                                 input logic h1, input logic h2, input logic d1, input logic d2);
        @(negedge clock);
        frameTick = tick;
        startBtn  = start;
        score     = 4'(sc);
        p1Hazard  = h1;
        p2Hazard  = h2;
        p1AtDoor  = d1;
        p2AtDoor  = d2;
        @(posedge clock);
        modelStep();
    endtask

    task automatic applyAsyncReset();
        @(negedge clock);
        #2 resetN = 1'b0;
        #1;
        checkOutput("rstState", dutState, int'(IDLE));
        checkOutput("rstTimer", dutTimerSec, TimeLimit);
        checkOutput("rstGemReset", dutGemReset, 0);
        checkOutput("rstPlayersEnable", dutPlayersEnable, 0);
        checkOutput("rstBlink", dutBlink, 0);
        checkOutput("rstLevelClear", dutLevelClear, 0);
        checkOutput("rstGameOver", dutGameOver, 0);
        resetModel();
        @(posedge clock);
        #2 resetN = 1'b1;
    endtask

    // Monitor: every output snapshot the driver predicted is compared here.
    initial begin
        outSnapshot_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("state", dutState, e.state);
                checkOutput("gemReset", dutGemReset, e.gemReset);
                checkOutput("playersEnable", dutPlayersEnable, e.playersEnable);
                checkOutput("timerSec", dutTimerSec, e.timerSec);
                checkOutput("blink", dutBlink, e.blink);
                checkOutput("levelClear", dutLevelClear, e.levelClear);
                checkOutput("gameOver", dutGameOver, e.gameOver);
            end
        end
    end

    initial begin
        resetN    = 1'b0;
        startBtn  = 1'b1;
        frameTick = 1'b0;
        score     = 4'd0;
        p1Hazard  = 1'b0;
        p2Hazard  = 1'b0;
        p1AtDoor  = 1'b0;
        p2AtDoor  = 1'b0;
        resetModel();
        @(posedge clock);
        #2;
        checkOutput("initState", dutState, int'(IDLE));
        checkOutput("initTimer", dutTimerSec, TimeLimit);
        checkOutput("initGemReset", dutGemReset, 0);
        @(posedge clock);
        #2 resetN = 1'b1;

        // Button held through reset must not start; a fresh press does.
        repeat (3) applyStimulus(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 checkOutput("heldNoStart", dutState, int'(IDLE));
        repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("pressState", dutState, int'(PLAY));
        checkOutput("pressGemReset", dutGemReset, 1);
        checkOutput("pressTimer", dutTimerSec, 3);
        checkOutput("pressEnable", dutPlayersEnable, 1);
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 checkOutput("gemResetOnce", dutGemReset, 0);

        // Countdown to zero, then OVER one cycle later.
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2 checkOutput("countdown", dutTimerSec, 3 - i / 4);
        end
        checkOutput("zeroStillPlay", dutState, int'(PLAY));
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("timeoutState", dutState, int'(OVER));
        checkOutput("timeoutGameOver", dutGameOver, 1);
        checkOutput("timeoutEnable", dutPlayersEnable, 0);
        repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 checkOutput("overToIdle", dutState, int'(IDLE));

        // Clear needs both players at their doors.
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 checkOutput("oneDoorPlay", dutState, int'(PLAY));
        applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("clearState", dutState, int'(CLEAR));
        checkOutput("clearFlag", dutLevelClear, 1);
        checkOutput("clearTimer", dutTimerSec, 3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1);
            #2;
            if (i < 4) checkOutput("clearBlink", dutBlink, (i == 1 || i == 2) ? 1 : 0);
        end
        checkOutput("clearToIdle", dutState, int'(IDLE));
        checkOutput("clearIdleTimer", dutTimerSec, 3);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 checkOutput("noStartFromClear", dutState, int'(IDLE));

        // Hazard beats a simultaneous clear.
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        checkOutput("hazardState", dutState, int'(OVER));
        checkOutput("hazardNoClear", dutLevelClear, 0);
        repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a level.
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyAsyncReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random play.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                applyAsyncReset();
            end else begin
                applyStimulus($urandom_range(0, 1) == 1,
                              $urandom_range(0, 7) == 0,
                              int'($urandom_range(0, 3)),
                              $urandom_range(0, 59) == 0,
                              $urandom_range(0, 59) == 0,
                              $urandom_range(0, 2) != 0,
                              $urandom_range(0, 2) != 0);
            end
        end

        @(posedge clock);
        #3 checkOutput("queueDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Sequences one level of play around the gem/score datapath.
  - Restarts the gem array at level start.
  - Gates player motion.
  - Runs the level countdown timer.
  - Decides level-clear versus game-over from score, door and hazard status.
- Sits between the top-level, the ScoreController/Gem array and the player movement blocks.
- All timing is in frames, driven by a one-cycle vsync tick.

Parameters:
- GEM_COUNT, 2, number of gems; level is clearable when score >= GEM_COUNT.
- FRAME_RATE, 60, frame ticks per timer second.
- TIME_LIMIT_S, 120, countdown start value in seconds; 1..255.
- HOLD_FRAMES, 180, frames spent in CLEAR/OVER before returning to IDLE; 1..1023.
- BLINK_FRAMES, 16, frames per blink half-period in CLEAR/OVER.

Ports:
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse per frame (vsync edge).
- start_btn, in, 1, level start button, level-sensitive, already synchronised.
- score, in, 4, collected gem count from ScoreController.
- p1_hazard, in, 1, player 1 touching a lethal pool.
- p2_hazard, in, 1, player 2 touching a lethal pool.
- p1_at_door, in, 1, player 1 inside its exit door.
- p2_at_door, in, 1, player 2 inside its exit door.
- state, out, 2, current game_state_t.
- gem_reset, out, 1, one-cycle pulse restoring all gems and score.
- players_enable, out, 1, high only in PLAY.
- timer_sec, out, 8, remaining seconds.
- blink, out, 1, overlay blink phase.
- level_clear, out, 1, high in CLEAR.
- game_over, out, 1, high in OVER.

Behaviour:
- Reset (Reset_n low, asynchronous) sets:
  - state=IDLE, gem_reset=0, players_enable=0, timer_sec=TIME_LIMIT_S, blink=0, level_clear=0, game_over=0.
  - All internal counters to 0 and the start_btn history register to 1, so a button held through reset does not start a level.
- All outputs are registered or are pure decodes of registered state; no input-to-output combinational path.
- start edge = start_btn high this cycle and low the previous cycle.
- IDLE:
  - On a start edge: go to PLAY, pulse gem_reset for exactly 1 cycle, load timer_sec=TIME_LIMIT_S, clear the frame counter.
  - frame_tick is ignored.
- PLAY:
  - Each frame_tick increments the frame counter.
  - When the counter equals FRAME_RATE-1 on a tick, it wraps to 0 and timer_sec decrements, saturating at 0.
  - Exit checks are evaluated every cycle on registered/inputs, in this priority:
    1. p1_hazard or p2_hazard -> OVER.
    2. timer_sec==0 -> OVER. This is entered the cycle after timer_sec reaches 0.
    3. score>=GEM_COUNT and p1_at_door and p2_at_door -> CLEAR.
  - Hazard wins over a simultaneous clear condition.
  - Start edges are ignored.
- CLEAR / OVER:
  - timer_sec is frozen.
  - The hold counter counts frame_ticks; when it reaches HOLD_FRAMES-1 on a tick, go to IDLE and clear the hold counter.
  - blink toggles each time BLINK_FRAMES ticks elapse; blink is forced to 0 outside CLEAR/OVER.
  - Start edges are ignored until IDLE.
- On entering IDLE, timer_sec reloads TIME_LIMIT_S.
- gem_reset never asserts except on the IDLE->PLAY transition.
- A frame_tick coinciding with a state change is consumed by the old state's counters only.
- Reset mid-level returns to IDLE immediately; no gem_reset pulse is generated. The top-level ORs Reset into the gem reset.

Decomposition:
- Package game_flow_pkg:
  - game_state_t enum (IDLE=2'd0, PLAY=2'd1, CLEAR=2'd2, OVER=2'd3).
  - TIMER_W=8 and HOLD_W=10 constants.
- Sub-module frame_sec_timer: frame prescaler plus seconds down-counter with load/enable/freeze controls, reused for the hold and blink counters via a mode-less instance per counter.
- The FSM lives in game_flow_controller.

Test Plan (FRAME_RATE=4, TIME_LIMIT_S=3, HOLD_FRAMES=5, BLINK_FRAMES=2 for bench speed):
- Reset with start_btn held high, then release and press -> no PLAY until the second press; then state=PLAY, gem_reset high for exactly 1 cycle, timer_sec=3, players_enable=1.
- In PLAY, 12 frame_ticks, no events -> timer_sec steps 3,2,1,0 at ticks 4,8,12; OVER entered the next cycle; game_over=1, players_enable=0.
- In PLAY, score=2 with p1_at_door=1 and p2_at_door=0 -> stays PLAY; raise p2_at_door -> CLEAR next cycle, level_clear=1, timer_sec frozen.
- In PLAY, same cycle: score=2, both at door, p2_hazard=1 -> OVER, not CLEAR.
- In CLEAR, 5 frame_ticks -> blink pattern 0,1,1,0 across ticks 2 and 4; IDLE after tick 5; timer_sec=3; start presses during CLEAR have no effect.
- Assert Reset_n low mid-PLAY, between clock edges -> outputs reach reset values immediately; state=IDLE, timer_sec=3, gem_reset stays 0.
